// File: rtl/rpn_stack_alu.sv
// Postfix (RPN) evaluation engine: DEPTH-entry operand stack, single-cycle ADD/SUB/MUL,
// restoring divider for DIV/MOD, sticky error flags {unbal, div0, under, over}.
module rpn_stack_alu #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 32,
   localparam int SP_W   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic              tok_op,
   input  logic [DATA_W-1:0] tok_data,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic [SP_W-1:0]   depth,
   output logic [3:0]        err,
   output logic              busy
);

   // state | meaning
   // IDLE  | accepting tokens, pushes and op dispatch
   // EXEC  | one-cycle ADD/SUB/MUL commit
   // DIV   | DATA_W divider steps, then commit quotient/remainder
   // ERR   | error latched; tokens dropped until CLR
   typedef enum logic [1:0] {IDLE, EXEC, DIV, ERR} state_t;

   localparam int              AW    = SP_W - 1;
   localparam int              CNT_W = $clog2(DATA_W + 1);
   localparam logic [SP_W-1:0] FULL  = SP_W'(DEPTH);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;
   localparam logic [2:0] OP_EQU = 3'd5;
   localparam logic [2:0] OP_CLR = 3'd6;

   state_t            state;
   logic [DATA_W-1:0] stk [DEPTH];
   logic [2:0]        op_r;
   logic [DATA_W-1:0] opa, opb;
   logic [DATA_W-1:0] rem_r, quo_r;
   logic [CNT_W-1:0]  cnt;

   logic [SP_W-1:0]   tos_p, nos_p;
   logic [DATA_W-1:0] tos, nos;
   logic [2:0]        code;
   logic [DATA_W-1:0] alu_y;
   logic [DATA_W:0]   shifted, diff;

   logic              stk_we;
   logic [AW-1:0]     stk_wa;
   logic [DATA_W-1:0] stk_wd;

   assign tos_p   = depth - SP_W'(1);
   assign nos_p   = depth - SP_W'(2);
   assign tos     = stk[tos_p[AW-1:0]];
   assign nos     = stk[nos_p[AW-1:0]];
   assign code    = tok_data[2:0];
   assign shifted = {rem_r, quo_r[DATA_W-1]};
   assign diff    = shifted - {1'b0, opb};

   always_comb begin
      alu_y = '0;
      case (op_r)
         OP_ADD:  alu_y = opa + opb;
         OP_SUB:  alu_y = opa - opb;
         OP_MUL:  alu_y = opa * opb;
         default: alu_y = '0;
      endcase
   end

   always_comb begin
      stk_we = 1'b0;
      stk_wa = '0;
      stk_wd = '0;
      case (state)
         IDLE: if (tok_valid && !tok_op && depth != FULL) begin
            stk_we = 1'b1;
            stk_wa = depth[AW-1:0];
            stk_wd = tok_data;
         end
         EXEC: begin
            stk_we = 1'b1;
            stk_wa = nos_p[AW-1:0];
            stk_wd = alu_y;
         end
         DIV: if (cnt == '0) begin
            stk_we = 1'b1;
            stk_wa = nos_p[AW-1:0];
            stk_wd = (op_r == OP_DIV) ? quo_r : rem_r;
         end
         default: ;
      endcase
   end

   // Storage has no reset; entries above depth are never observed.
   always_ff @(posedge clk) begin
      if (stk_we) stk[stk_wa] <= stk_wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         depth        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         err          <= '0;
         busy         <= 1'b0;
         tok_ready    <= 1'b1;
         op_r         <= '0;
         opa          <= '0;
         opb          <= '0;
         rem_r        <= '0;
         quo_r        <= '0;
         cnt          <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: if (tok_valid) begin
               if (!tok_op) begin
                  if (depth == FULL) begin
                     err[0] <= 1'b1;
                     state  <= ERR;
                  end else begin
                     depth <= depth + SP_W'(1);
                  end
               end else begin
                  case (code)
                     OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
                        if (depth < SP_W'(2)) begin
                           err[1] <= 1'b1;
                           state  <= ERR;
                        end else if ((code == OP_DIV || code == OP_MOD) && tos == '0) begin
                           err[2] <= 1'b1;
                           state  <= ERR;
                        end else begin
                           op_r      <= code;
                           opa       <= nos;
                           opb       <= tos;
                           busy      <= 1'b1;
                           tok_ready <= 1'b0;
                           if (code == OP_DIV || code == OP_MOD) begin
                              rem_r <= '0;
                              quo_r <= nos;
                              cnt   <= CNT_W'(DATA_W);
                              state <= DIV;
                           end else begin
                              state <= EXEC;
                           end
                        end
                     end
                     OP_EQU: begin
                        if (depth == SP_W'(1)) begin
                           result       <= tos;
                           result_valid <= 1'b1;
                           depth        <= '0;
                        end else if (depth == '0) begin
                           err[1] <= 1'b1;
                           state  <= ERR;
                        end else begin
                           err[3] <= 1'b1;
                           state  <= ERR;
                        end
                     end
                     OP_CLR: begin
                        depth <= '0;
                        err   <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            EXEC: begin
               depth     <= depth - SP_W'(1);
               busy      <= 1'b0;
               tok_ready <= 1'b1;
               state     <= IDLE;
            end
            DIV: begin
               if (cnt != '0) begin
                  // Restoring step: keep the trial difference only when it did not borrow.
                  if (!diff[DATA_W]) begin
                     rem_r <= diff[DATA_W-1:0];
                     quo_r <= {quo_r[DATA_W-2:0], 1'b1};
                  end else begin
                     rem_r <= shifted[DATA_W-1:0];
                     quo_r <= {quo_r[DATA_W-2:0], 1'b0};
                  end
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  depth     <= depth - SP_W'(1);
                  busy      <= 1'b0;
                  tok_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            ERR: if (tok_valid && tok_op && code == OP_CLR) begin
               depth <= '0;
               err   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// Bench for rpn_stack_alu: directed scenarios plus random token streams against a queue-based model,
// on a 32-deep and a 4-deep instance sharing the token bus.
module tb_rpn_stack_alu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tok_valid = 1'b0;
   logic        tok_op = 1'b0;
   logic [31:0] tok_data = '0;
   logic        sel = 1'b0;

   logic        ready_a, rv_a, busy_a, ready_b, rv_b, busy_b;
   logic [31:0] res_a, res_b;
   logic [5:0]  depth_a;
   logic [2:0]  depth_b;
   logic [3:0]  err_a, err_b;

   wire tv_a = tok_valid & ~sel;
   wire tv_b = tok_valid & sel;

   rpn_stack_alu dut_a (
      .clk(clk), .rst(rst), .tok_valid(tv_a), .tok_ready(ready_a), .tok_op(tok_op),
      .tok_data(tok_data), .result(res_a), .result_valid(rv_a), .depth(depth_a),
      .err(err_a), .busy(busy_a));

   rpn_stack_alu #(.DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .tok_valid(tv_b), .tok_ready(ready_b), .tok_op(tok_op),
      .tok_data(tok_data), .result(res_b), .result_valid(rv_b), .depth(depth_b),
      .err(err_b), .busy(busy_b));

   wire        ready_m = sel ? ready_b : ready_a;
   wire        rv_m    = sel ? rv_b    : rv_a;
   wire        busy_m  = sel ? busy_b  : busy_a;
   wire [31:0] res_m   = sel ? res_b   : res_a;
   wire [5:0]  depth_m = sel ? {3'b000, depth_b} : depth_a;
   wire [3:0]  err_m   = sel ? err_b   : err_a;

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: operand stack as a queue, per-instance result.
   logic [31:0] mstk[$];
   logic [3:0]  m_err;
   logic [31:0] m_res [2];
   bit          m_in_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      mstk.delete();
      m_err    = '0;
      m_res[0] = '0;
      m_res[1] = '0;
      m_in_err = 0;
   endfunction

   function automatic void model_tok(input bit op, input logic [31:0] d);
      logic [31:0] a, b;
      int lim = sel ? 4 : 32;
      if (m_in_err) begin
         if (op && d[2:0] == 3'd6) begin
            mstk.delete();
            m_err    = '0;
            m_in_err = 0;
         end
      end else if (!op) begin
         if (mstk.size() == lim) begin
            m_err[0] = 1'b1;
            m_in_err = 1;
         end else begin
            mstk.push_back(d);
         end
      end else begin
         case (d[2:0])
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
               if (mstk.size() < 2) begin
                  m_err[1] = 1'b1;
                  m_in_err = 1;
               end else if ((d[2:0] == 3'd3 || d[2:0] == 3'd4) && mstk[mstk.size()-1] == 0) begin
                  m_err[2] = 1'b1;
                  m_in_err = 1;
               end else begin
                  b = mstk.pop_back();
                  a = mstk.pop_back();
                  case (d[2:0])
                     3'd0:    mstk.push_back(a + b);
                     3'd1:    mstk.push_back(a - b);
                     3'd2:    mstk.push_back(32'((64'(a) * 64'(b)) % 64'h1_0000_0000));
                     3'd3:    mstk.push_back(a / b);
                     default: mstk.push_back(a % b);
                  endcase
               end
            end
            3'd5: begin
               if (mstk.size() == 1) m_res[sel] = mstk.pop_back();
               else begin
                  if (mstk.size() == 0) m_err[1] = 1'b1;
                  else m_err[3] = 1'b1;
                  m_in_err = 1;
               end
            end
            3'd6: begin
               mstk.delete();
               m_err = '0;
            end
            default: ;
         endcase
      end
   endfunction

   // Returns at posedge+1 after the transfer.
   task automatic send(input bit op, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      tok_valid = 1'b1;
      tok_op    = op;
      tok_data  = d;
      while (!ready_m && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("ready_wait", ready_m, 1);
      @(posedge clk);
      #1;
      tok_valid = 1'b0;
      model_tok(op, d);
   endtask

   task automatic settle(input string tag);
      int n = 0;
      @(negedge clk);
      while (!ready_m && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk({tag, "_ready_wait"}, ready_m, 1);
      chk({tag, "_depth"}, depth_m, 64'(mstk.size()));
      chk({tag, "_err"}, err_m, m_err);
      chk({tag, "_result"}, res_m, m_res[sel]);
   endtask

   task automatic ready_low(input string tag, input int exp);
      int n = 0;
      @(negedge clk);
      while (!ready_m && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk(tag, n, exp);
   endtask

   initial begin
      int r;
      logic [31:0] v;
      model_reset();
      @(negedge clk);
      chk("rst_depth", depth_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_result", res_a, 0);
      chk("rst_rv", rv_a, 0);
      chk("rst_busy", busy_a, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready_a, 1);

      // 3 4 + 2 * =
      send(0, 3); send(0, 4);
      send(1, 0); ready_low("add_latency", 1);
      send(0, 2); send(1, 2);
      send(1, 5);
      chk("t1_rv_hi", rv_m, 1);
      chk("t1_res", res_m, 14);
      @(posedge clk); #1;
      chk("t1_rv_lo", rv_m, 0);
      settle("t1");

      // Overflow on the 4-deep instance
      sel = 1'b1;
      for (int i = 1; i <= 5; i++) send(0, i);
      settle("t2_over");
      chk("t2_err_const", err_m, 4'b0001);
      send(1, 0);
      settle("t2_drop");
      send(1, 6);
      chk("t2_clr_no_rv", rv_m, 0);
      settle("t2_clr");
      sel = 1'b0;

      // Divider
      send(0, 100); send(0, 7);
      send(1, 3); ready_low("div_latency", 33);
      send(1, 5); settle("t3_div");
      chk("t3_div_const", res_m, 14);
      send(0, 100); send(0, 7); send(1, 4); send(1, 5); settle("t3_mod");
      chk("t3_mod_const", res_m, 2);
      send(0, 7); send(0, 0); send(1, 3); settle("t3_div0");
      chk("t3_div0_const", err_m, 4'b0100);
      send(1, 6);

      // Underflow and unbalanced
      send(0, 5); send(1, 0); settle("t4_under");
      chk("t4_under_const", err_m, 4'b0010);
      send(1, 6);
      send(0, 1); send(0, 2); send(1, 5); settle("t4_unbal");
      chk("t4_unbal_const", err_m, 4'b1000);
      send(1, 6);

      // Wrap-around, MUL truncation, reserved op
      send(0, 0); send(0, 1); send(1, 1); send(1, 5); settle("t5_sub");
      chk("t5_sub_const", res_m, 32'hFFFF_FFFF);
      send(0, 32'h1_0000); send(0, 32'h1_0000); send(1, 2); send(1, 5); settle("t5_mul");
      chk("t5_mul_const", res_m, 0);
      send(0, 9); send(1, 7); settle("t5_rsvd");
      send(1, 6);

      // Back-to-back numbers
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         tok_valid = 1'b1;
         tok_op    = 1'b0;
         tok_data  = 32'(i + 20);
         chk("t5_b2b_ready", ready_m, 1);
         @(posedge clk);
         model_tok(0, 32'(i + 20));
         @(negedge clk);
      end
      tok_valid = 1'b0;
      settle("t5_b2b");
      send(1, 6);

      // Reset during DIV
      send(0, 100); send(0, 7); send(1, 3);
      repeat (9) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t6_busy", busy_a, 0);
      chk("t6_depth", depth_a, 0);
      chk("t6_err", err_a, 0);
      chk("t6_result", res_a, 0);
      chk("t6_rv", rv_a, 0);
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_ready", ready_a, 1);
      send(0, 9); send(1, 5); settle("t6_after");
      chk("t6_after_const", res_m, 9);

      // Random streams on both instances
      for (int pass = 0; pass < 2; pass++) begin
         sel = pass[0];
         send(1, 6);
         for (int i = 0; i < (pass == 0 ? 400 : 150); i++) begin
            r = int'($urandom_range(0, 9));
            if (m_in_err && $urandom_range(0, 2) == 0) send(1, 6);
            else if (r < 5) begin
               v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
               send(0, v);
            end else begin
               v = 32'($urandom_range(0, 7));
               if (v == 6 && $urandom_range(0, 1) == 0) v = 5;
               send(1, v);
            end
            settle("rand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
